memory_ram_slave: RTL

Word-organised RAM that terminates the slave side of the `Memory` bus. It sits directly downstream of any bus master (core fetch/load-store unit) and serves its load and store requests in order. Loads pass through a fixed-latency read pipeline into a small response FIFO. That FIFO honours master back-pressure on the response channel. Request acceptance is credit-limited so no response is ever dropped.

---
 rtl/memory_ram_slave.sv | 114 +++++++++++
 1 files changed

// File: rtl/memory_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : memory_ram_slave
// Brief    : Word RAM terminating the Memory bus slave side; fixed-latency
//            load pipeline feeding a credit-limited response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module memory_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int RESP_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_address,
    input  logic [31:0] m_data,
    input  logic        m_write,
    input  logic        m_valid,
    output logic        m_ready,
    output logic [31:0] s_data,
    output logic        s_valid,
    input  logic        s_ready
);

    localparam int c_addr_w = $clog2(DEPTH_WORDS);
    localparam int c_cnt_w  = $clog2(RESP_DEPTH + 1);
    localparam int c_ptr_w  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_resp_depth = c_cnt_w'(RESP_DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr   = c_ptr_w'(RESP_DEPTH - 1);

    logic [31:0]         r_mem [DEPTH_WORDS];
    logic [LATENCY-1:0]  r_pipe_valid;
    logic [31:0]         r_pipe_data [LATENCY];
    logic [31:0]         r_fifo [RESP_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_fifo_count;
    logic [c_cnt_w-1:0]  r_outstanding;
    logic [31:0]         r_last_data;
    logic                r_rst_q;

    logic [c_addr_w-1:0] w_index;
    logic                w_accept;
    logic                w_load;
    logic                w_store;
    logic                w_push;
    logic                w_pop;
    logic                w_unused_addr;

    function automatic logic [c_ptr_w-1:0] f_next_ptr(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_last_ptr) ? '0 : ptr + 1'b1;
    endfunction

    // Byte-offset and upper address bits are don't-care: words alias.
    assign w_index       = m_address[2 +: c_addr_w];
    assign w_unused_addr = ^{m_address[1:0], m_address >> (c_addr_w + 2)};

    // Credit covers stores too so the request channel stalls uniformly.
    assign m_ready  = !r_rst_q && (r_outstanding < c_resp_depth);
    assign w_accept = m_valid && m_ready && !rst;
    assign w_load   = w_accept && !m_write;
    assign w_store  = w_accept && m_write;
    assign w_push   = r_pipe_valid[LATENCY-1];
    assign w_pop    = s_valid && s_ready;

    assign s_valid = (r_fifo_count != '0);
    assign s_data  = s_valid ? r_fifo[r_rd_ptr] : r_last_data;

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_index] <= m_data;
        end
        if (w_load) begin
            r_pipe_data[0] <= r_mem[w_index];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < LATENCY; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= r_pipe_data[LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst) begin
            r_pipe_valid  <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_count  <= '0;
            r_outstanding <= '0;
            r_last_data   <= '0;
        end else begin
            r_pipe_valid[0] <= w_load;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
            end
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr    <= f_next_ptr(r_rd_ptr);
                r_last_data <= r_fifo[r_rd_ptr];
            end
            r_fifo_count  <= r_fifo_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            r_outstanding <= r_outstanding + c_cnt_w'(w_load) - c_cnt_w'(w_pop);
        end
    end

endmodule
`default_nettype wire
